// File: rtl/stack_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stack_ctrl_pkg
//  Description : Shared types and constants for the stack memory sequencer.
//                Holds the FSM state encoding, the latched-request opcode
//                encoding and the default word width / depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package stack_ctrl_pkg;

  localparam int STACK_DATA_W = 8;
  localparam int STACK_DEPTH  = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PUSH_WR = 3'd1,
    RD      = 3'd2,
    CAP     = 3'd3,
    DONE    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_PUSH = 2'd0,
    OP_POP  = 2'd1,
    OP_TOS  = 2'd2
  } op_t;

endpackage
`default_nettype wire

// File: rtl/stack_pointer.sv
`default_nettype none
// ============================================================================
//  Module      : stack_pointer
//  Description : Up/down entry counter for the stack, with full/empty decode.
//                The count saturates at 0 and DEPTH, so it never wraps.
//  Ports       : clk   - system clock, rising edge
//                rst   - asynchronous, active-low reset
//                inc   - add one entry (ignored when full)
//                dec   - remove one entry (ignored when empty)
//                sp    - number of stored entries, 0..DEPTH
//                full  - sp == DEPTH
//                empty - sp == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_pointer
  import stack_ctrl_pkg::*;
#(
  parameter int DEPTH  = STACK_DEPTH,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W:0]   sp,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] c_one   = (ADDR_W+1)'(1);

  logic [ADDR_W:0] r_sp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sp <= '0;
    end else if (inc && !full) begin
      r_sp <= r_sp + c_one;
    end else if (dec && !empty) begin
      r_sp <= r_sp - c_one;
    end
  end

  assign sp    = r_sp;
  assign full  = (r_sp == c_depth);
  assign empty = (r_sp == '0);

endmodule
`default_nettype wire

// File: rtl/stack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stack_ctrl
//  Description : Stack memory sequencer. Accepts push/pop/tos requests in
//                IDLE, drives a synchronous-read stack RAM, owns the stack
//                pointer and sticky overflow/underflow flags, and returns
//                popped / top-of-stack data with a one-cycle done pulse.
//  Ports       : clk, rst (async active-low)
//                push/pop/tos - requests, sampled only in IDLE (pop>push>tos)
//                clr_err      - clears overflow/underflow (new error wins)
//                din / dout   - push data in / registered pop-tos result
//                busy, done   - state != IDLE / completion pulse
//                full, empty, overflow, underflow, sp - status
//                mem_addr, mem_wdata, mem_we, mem_rdata - stack RAM port
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int DATA_W = STACK_DATA_W,
  parameter int DEPTH  = STACK_DEPTH,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              tos,
  input  logic              clr_err,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W:0]   sp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  op_t                 r_op;
  op_t                 w_op_nxt;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   w_wdata_nxt;
  logic [DATA_W-1:0]   r_dout;
  logic                r_ovf;
  logic                r_udf;
  logic                w_set_ovf;
  logic                w_set_udf;
  logic                w_inc;
  logic                w_dec;
  logic                w_full;
  logic                w_empty;
  logic [ADDR_W:0]     w_sp;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [ADDR_W-1:0]   w_mem_addr;

  // Pointer moves only from decoded states, so a reset in PUSH_WR/RD
  // cannot leave a half-finished pointer update behind.
  assign w_inc = (r_state == PUSH_WR);
  assign w_dec = (r_state == RD) && (r_op == OP_POP);

  stack_pointer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_stack_pointer (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_inc),
    .dec   (w_dec),
    .sp    (w_sp),
    .full  (w_full),
    .empty (w_empty)
  );

  // Top entry lives at sp-1; modulo-DEPTH arithmetic on the low bits gives
  // DEPTH-1 when sp == DEPTH.
  assign w_rd_addr = w_sp[ADDR_W-1:0] - c_addr_one;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_op    <= OP_PUSH;
      r_wdata <= '0;
      r_dout  <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_wdata <= w_wdata_nxt;
      if (r_state == CAP) begin
        r_dout <= mem_rdata;
      end
      // A new error in the same cycle as clr_err leaves the flag set.
      r_ovf <= w_set_ovf | (r_ovf & ~clr_err);
      r_udf <= w_set_udf | (r_udf & ~clr_err);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_wdata_nxt = r_wdata;
    w_set_ovf   = 1'b0;
    w_set_udf   = 1'b0;
    case (r_state)
      IDLE: begin
        if (pop) begin
          if (w_empty) begin
            w_set_udf   = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_op_nxt    = OP_POP;
            w_state_nxt = RD;
          end
        end else if (push) begin
          if (w_full) begin
            w_set_ovf   = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_op_nxt    = OP_PUSH;
            w_wdata_nxt = din;
            w_state_nxt = PUSH_WR;
          end
        end else if (tos) begin
          if (w_empty) begin
            w_set_udf   = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_op_nxt    = OP_TOS;
            w_state_nxt = RD;
          end
        end
      end
      PUSH_WR: w_state_nxt = DONE;
      RD:      w_state_nxt = CAP;
      CAP:     w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_mem_addr = '0;
    case (r_state)
      PUSH_WR: w_mem_addr = w_sp[ADDR_W-1:0];
      RD:      w_mem_addr = w_rd_addr;
      default: w_mem_addr = '0;
    endcase
  end

  assign mem_addr  = w_mem_addr;
  assign mem_we    = (r_state == PUSH_WR);
  assign mem_wdata = r_wdata;
  assign dout      = r_dout;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_ovf;
  assign underflow = r_udf;
  assign sp        = w_sp;

endmodule
`default_nettype wire

// File: tb/tb_stack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stack_ctrl
//  Description : Self-checking bench for stack_ctrl. Table of operations with
//                expected results, a queue of expected RAM writes checked by
//                a write monitor, and hand sequences for clr_err, busy-time
//                requests and reset during a write.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_ctrl;

  localparam int DW = 8;
  localparam int DP = 8;
  localparam int AW = 3;

  localparam int OPUSH = 0;
  localparam int OPOP  = 1;
  localparam int OTOS  = 2;
  localparam int OBOTH = 3;   // push and pop together

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push = 1'b0, pop = 1'b0, tos = 1'b0, clr_err = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy, done, full, empty, overflow, underflow, mem_we;
  logic [AW:0]   sp;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stack_ctrl #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos),
    .clr_err(clr_err), .din(din), .dout(dout), .busy(busy), .done(done),
    .full(full), .empty(empty), .overflow(overflow), .underflow(underflow),
    .sp(sp), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  // Synchronous-read stack RAM
  logic [DW-1:0] ram [DP];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Expected-write scoreboard
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t wr_q[$];

  always @(negedge clk) begin
    if (rst && mem_we) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h, expected no write",
                 mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          errors++;
          $display("FAIL ram_write: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          op;
    logic [DW-1:0] din;
    int          lat;
    logic [DW-1:0] dout;
    int          sp;
    bit          ovf;
    bit          udf;
    bit          wr;
  } row_t;

  row_t tbl [21];

  task automatic set_row(input int i, input int op, input logic [DW-1:0] d, input int lat,
                         input logic [DW-1:0] q, input int s, input bit o, input bit u,
                         input bit w);
    tbl[i].op = op; tbl[i].din = d; tbl[i].lat = lat; tbl[i].dout = q;
    tbl[i].sp = s; tbl[i].ovf = o; tbl[i].udf = u; tbl[i].wr = w;
  endtask

  // Cycles from the accept edge until done is seen (1 = done right after accept).
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_row(input int i);
    row_t r;
    int   lat;
    r = tbl[i];
    @(negedge clk);
    din  = r.din;
    push = (r.op == OPUSH) || (r.op == OBOTH);
    pop  = (r.op == OPOP)  || (r.op == OBOTH);
    tos  = (r.op == OTOS);
    if (r.wr) wr_q.push_back(wr_t'{addr: AW'(r.sp - 1), data: r.din});
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; tos = 1'b0;
    check($sformatf("row%0d_busy", i), busy, 1);
    wait_done(lat);
    check($sformatf("row%0d_latency", i), lat, r.lat);
    check($sformatf("row%0d_dout", i), dout, r.dout);
    check($sformatf("row%0d_sp", i), sp, r.sp);
    check($sformatf("row%0d_overflow", i), overflow, r.ovf);
    check($sformatf("row%0d_underflow", i), underflow, r.udf);
    check($sformatf("row%0d_full", i), full, (r.sp == DP));
    check($sformatf("row%0d_empty", i), empty, (r.sp == 0));
    @(posedge clk); #1;
    check($sformatf("row%0d_idle", i), busy, 0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  initial begin
    int lat;

    set_row(0, OPUSH, 8'h11, 2, 8'h00, 1, 0, 0, 1);
    set_row(1, OPUSH, 8'h22, 2, 8'h00, 2, 0, 0, 1);
    set_row(2, OPUSH, 8'h33, 2, 8'h00, 3, 0, 0, 1);
    set_row(3, OPOP,  8'h00, 3, 8'h33, 2, 0, 0, 0);
    set_row(4, OPOP,  8'h00, 3, 8'h22, 1, 0, 0, 0);
    set_row(5, OPOP,  8'h00, 3, 8'h11, 0, 0, 0, 0);
    set_row(6, OPOP,  8'h00, 1, 8'h11, 0, 0, 1, 0);
    set_row(7, OTOS,  8'h00, 1, 8'h11, 0, 0, 1, 0);
    for (int k = 0; k < 8; k++)
      set_row(8 + k, OPUSH, 8'hA0 + 8'(k), 2, 8'h11, k + 1, 0, 0, 1);
    set_row(16, OPUSH, 8'hFF, 1, 8'h11, 8, 1, 0, 0);
    set_row(17, OTOS,  8'h00, 3, 8'hA7, 8, 1, 0, 0);
    set_row(18, OPUSH, 8'h66, 2, 8'h00, 1, 0, 0, 1);
    set_row(19, OPUSH, 8'h77, 2, 8'h00, 2, 0, 0, 1);
    set_row(20, OBOTH, 8'h99, 3, 8'h77, 1, 0, 0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_sp", sp, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_dout", dout, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underflow", underflow, 0);
    rst = 1'b1;

    for (int i = 0; i <= 7; i++) run_row(i);

    pulse_clr();
    check("clr_underflow", underflow, 0);
    check("clr_overflow", overflow, 0);

    for (int i = 8; i <= 17; i++) run_row(i);

    pulse_clr();
    check("clr2_overflow", overflow, 0);

    // Push on a full stack together with clr_err: the new error wins
    @(negedge clk);
    push = 1'b1; clr_err = 1'b1; din = 8'hEE;
    @(posedge clk); #1;
    push = 1'b0; clr_err = 1'b0;
    check("coincide_overflow", overflow, 1);
    check("coincide_done", done, 1);
    check("coincide_sp", sp, 8);
    @(posedge clk); #1;
    check("coincide_idle", busy, 0);

    // Reset asserted during PUSH_WR
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    push = 1'b1; din = 8'h55;
    @(posedge clk); #1;
    push = 1'b0;
    check("pushwr_mem_we", mem_we, 1);
    check("pushwr_mem_addr", mem_addr, 0);
    rst = 1'b0;
    #1;
    check("midrst_mem_we", mem_we, 0);
    check("midrst_sp", sp, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_underflow", underflow, 0);
    repeat (2) @(negedge clk);
    check("midrst_sp_held", sp, 0);
    rst = 1'b1;

    // First push after reset lands at addr 0, then arbitration pop > push
    for (int i = 18; i <= 20; i++) run_row(i);

    // Requests held while busy are ignored
    @(negedge clk);
    pop = 1'b1;
    @(posedge clk); #1;
    push = 1'b1; pop = 1'b1; tos = 1'b1; din = 8'hAB;
    wait_done(lat);
    push = 1'b0; pop = 1'b0; tos = 1'b0;
    check("busyreq_latency", lat, 3);
    check("busyreq_dout", dout, 8'h66);
    check("busyreq_sp", sp, 0);
    check("busyreq_empty", empty, 1);
    @(posedge clk); #1;
    check("busyreq_idle", busy, 0);
    check("busyreq_sp_after", sp, 0);
    repeat (2) @(posedge clk);
    #1;
    check("pending_writes", wr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
